acq_search_scheduler: RTL

Dwell-rate controller that schedules the acquisition search of one GPS channel. Clocked by the 1 ms accumulator-clear pulse, it counts code-phase dwells, steps the carrier Doppler bin in zig-zag order, rolls the satellite after a full sweep, and runs a verify/lock/loss state machine on the threshold detector's `acq` flag. Outputs feed the carrier NCO offset, the code-control reset and the satellite-select mux.

---
 rtl/acq_search_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/acq_search_scheduler.sv
// Acquisition search scheduler for one GPS channel: dwell counting, zig-zag
// Doppler bin stepping, satellite roll per sweep and verify/lock/loss FSM.
module acq_search_scheduler #(
  parameter int unsigned CODE_POS = 2046,
  parameter int unsigned NBIN     = 10,
  parameter logic [29:0] STEP     = 30'd93957,
  parameter int unsigned CONFIRM  = 8,
  parameter int unsigned LOSS     = 20
) (
  input  logic        tr_accclr_clk1ms,
  input  logic        mclr,
  input  logic        enable_i,
  input  logic        acq_i,
  output logic [29:0] car_offset_o,
  output logic        car_step_o,
  output logic        sat_change_o,
  output logic        locked_o,
  output logic [1:0]  state_o,
  output logic [4:0]  bin_o,
  output logic [10:0] dwell_o
);

  localparam int unsigned VW = $clog2(CONFIRM + 1);
  localparam int unsigned MW = $clog2(LOSS + 1);
  localparam logic [10:0] DWELL_LAST = 11'(CODE_POS - 1);
  localparam logic signed [4:0] BIN_MIN = -5'(NBIN);
  localparam logic [VW-1:0] VCNT_LAST = VW'(CONFIRM - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    VERIFY = 2'b10,
    LOCK   = 2'b11
  } state_t;

  state_t             r_state, w_state_n;
  logic [10:0]        r_dwell, w_dwell_n;
  logic signed [4:0]  r_bin, w_bin_n;
  logic [29:0]        r_off, w_off_n;
  logic               r_step, w_step_n;
  logic               r_sat, w_sat_n;
  logic [VW-1:0]      r_vcnt, w_vcnt_n;
  logic [MW-1:0]      r_miss, w_miss_n;
  logic               w_adv;
  logic               w_pos;
  logic signed [4:0]  w_bin_step;
  logic [29:0]        w_off_step;

  // Zig-zag step: mirror a positive bin, otherwise mirror and move one outward;
  // the offset follows the same rule so no multiplier is needed.
  assign w_pos      = !r_bin[4] && (r_bin != '0);
  assign w_bin_step = w_pos ? -r_bin : -r_bin + 5'sd1;
  assign w_off_step = w_pos ? -r_off : -r_off + STEP;

  always_ff @(posedge tr_accclr_clk1ms or negedge mclr) begin
    if (!mclr) begin
      r_state <= IDLE;
      r_dwell <= '0;
      r_bin   <= '0;
      r_off   <= '0;
      r_step  <= 1'b0;
      r_sat   <= 1'b0;
      r_vcnt  <= '0;
      r_miss  <= '0;
    end else begin
      r_state <= w_state_n;
      r_dwell <= w_dwell_n;
      r_bin   <= w_bin_n;
      r_off   <= w_off_n;
      r_step  <= w_step_n;
      r_sat   <= w_sat_n;
      r_vcnt  <= w_vcnt_n;
      r_miss  <= w_miss_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_dwell_n = r_dwell;
    w_bin_n   = r_bin;
    w_off_n   = r_off;
    w_step_n  = 1'b0;
    w_sat_n   = r_sat;
    w_vcnt_n  = r_vcnt;
    w_miss_n  = r_miss;
    w_adv     = 1'b0;
    if (!enable_i) begin
      w_state_n = IDLE;
      w_dwell_n = '0;
      w_bin_n   = '0;
      w_off_n   = '0;
      w_vcnt_n  = '0;
      w_miss_n  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_n = SEARCH;
          w_dwell_n = '0;
        end
        SEARCH: begin
          if (acq_i) begin
            w_state_n = VERIFY;
            w_vcnt_n  = VW'(1);
          end else begin
            w_adv = 1'b1;
          end
        end
        VERIFY: begin
          if (acq_i) begin
            if (r_vcnt == VCNT_LAST) begin
              w_state_n = LOCK;
              w_vcnt_n  = '0;
              w_miss_n  = '0;
            end else begin
              w_vcnt_n = r_vcnt + 1'b1;
            end
          end else begin
            w_state_n = SEARCH;
            w_vcnt_n  = '0;
            w_adv     = 1'b1;
          end
        end
        LOCK: begin
          if (acq_i) begin
            w_miss_n = '0;
          end else if (r_miss == MISS_LAST) begin
            w_state_n = SEARCH;
            w_dwell_n = '0;
            w_miss_n  = '0;
          end else begin
            w_miss_n = r_miss + 1'b1;
          end
        end
        default: w_state_n = IDLE;
      endcase
    end

    // Shared dwell/bin advance for SEARCH misses and failed verifies
    if (w_adv) begin
      if (r_dwell == DWELL_LAST) begin
        w_dwell_n = '0;
        w_step_n  = 1'b1;
        if (r_bin == BIN_MIN) begin
          w_bin_n = '0;
          w_off_n = '0;
          w_sat_n = ~r_sat;
        end else begin
          w_bin_n = w_bin_step;
          w_off_n = w_off_step;
        end
      end else begin
        w_dwell_n = r_dwell + 1'b1;
      end
    end
  end

  assign car_offset_o = r_off;
  assign car_step_o   = r_step;
  assign sat_change_o = r_sat;
  assign locked_o     = (r_state == LOCK);
  assign state_o      = r_state;
  assign bin_o        = r_bin;
  assign dwell_o      = r_dwell;

endmodule
